dds_cfg_seq: RTL and testbench
==============================

# dds_cfg_seq

Register-write sequencer directly upstream of the DDS serial writer (`wr_cmd`). After reset it programs the DDS control registers and then accepts tone updates (frequency, phase, amplitude). Each update becomes a fixed burst of 32-bit register writes, handed to the serial writer one at a time, followed by an IO_UPDATE pulse that commits the new settings in the DDS.

## Interface
Parameters:
- `CFR1_VAL`, 32'h0000_0000, control register 1 word written at init.
- `CFR2_VAL`, 32'h0140_0820, control register 2 word written at init.
- `ADDR_CFR1` / `ADDR_CFR2` / `ADDR_FTW` / `ADDR_POW` / `ADDR_ASF`, 8'h00 / 8'h01 / 8'h07 / 8'h08 / 8'h09, register addresses.
- `IOUP_CYCLES`, 4, IO_UPDATE pulse width in clk cycles (≥1).
- `GAP_CYCLES`, 2, idle cycles between `wr_done` and the next `wr_start` (≥0).
- `TIMEOUT`, 4096, maximum cycles to wait for `wr_done` (≥2).

Ports:
- `clk` in 1: system clock. The block uses one clock only.
- `rst` in 1: reset. It is synchronous and active-high.
- `load` in 1: request a tone update. Sampled only when `ready`=1.
- `ftw` in 32: frequency tuning word.
- `pow` in 16: phase offset word.
- `asf` in 14: amplitude scale factor.
- `ready` out 1: idle and able to accept `load`.
- `err` out 1: sticky timeout flag. Cleared only by `rst`.
- `wr_start` out 1: one-cycle write strobe to the serial writer.
- `wr_addr` out 8: register address. Stable from `wr_start` until `wr_done`.
- `wr_data` out 32: register word. Stable from `wr_start` until `wr_done`.
- `wr_done` in 1: one-cycle completion pulse from the serial writer.
- `io_update` out 1: DDS IO_UPDATE pin.

## Operation
- Write list, indexed by `idx` 0..4:
  - 0: CFR1 ← `CFR1_VAL`.
  - 1: CFR2 ← `CFR2_VAL`.
  - 2: FTW ← latched `ftw`.
  - 3: POW ← {16'h0, latched `pow`}.
  - 4: ASF ← {16'h0, latched `asf`, 2'b00}.
- Init burst covers idx 0–1. Update burst covers idx 2–4.
- States are ISSUE, WAIT, GAP, IOUP and IDLE.
- After `rst`: the FSM enters ISSUE with idx=0.
- ISSUE: drive `wr_start`=1 for one cycle, with `wr_addr`/`wr_data` taken from the list at idx. Go to WAIT.
- WAIT: count cycles.
  - On `wr_done`=1: if idx is the last entry of the current burst (1 or 4), go to IOUP. Otherwise increment idx and go to GAP, or go straight to ISSUE if `GAP_CYCLES`=0.
  - If the count reaches `TIMEOUT` without `wr_done`: set `err`=1, abandon the burst, skip IO_UPDATE, go to IDLE.
- GAP: wait `GAP_CYCLES` cycles, then go to ISSUE.
- IOUP: hold `io_update`=1 for exactly `IOUP_CYCLES` cycles, then go to IDLE.
- IDLE: `ready`=1. When `load`=1, latch `ftw`/`pow`/`asf`, set idx=2 and go to ISSUE.
- `load` outside IDLE is ignored; no queueing.
- Input values are captured only at load acceptance. Later changes on `ftw`/`pow`/`asf` do not affect a burst in flight.
- `wr_done` outside WAIT is ignored.
- After a timeout the block still accepts `load`. `err` stays set.

## Timing
- Reset values: `ready`=0, `err`=0, `wr_start`=0, `wr_addr`=0, `wr_data`=0, `io_update`=0, idx=0, and all latches 0.
- `rst` asserted mid-burst or mid-IOUP aborts immediately and restarts the init burst. `io_update` drops in the same edge.
- All outputs are registered.
- `wr_start` rises on the edge after ISSUE is entered.
- `load` sampled high at edge N gives `ready`=0 after N and `wr_start`=1 after edge N+1.
- `wr_done` at edge M:
  - next `wr_start` follows after edge M+GAP_CYCLES+1.
  - or, for the last write, `io_update` rises after edge M+1.
- `ready` rises on the edge where `io_update` falls.
- A `wr_done` arriving in the same cycle the timeout count expires counts as success.
- The timeout counter is cleared on every ISSUE. Its width is `$clog2(TIMEOUT+1)`.

## Structure
- Shared package `dds_pkg`:
  - state enum.
  - register address constants.
  - ASF/POW word-packing functions, reused by other DDS stages.
- No sub-module is needed. The list mux is a combinational case on idx inside the block.
- One shared down-counter serves GAP, IOUP and timeout.

## Test plan
- Reset, then serial-writer model returns `wr_done` 20 cycles after each `wr_start` → writes (00, 00000000) then (01, 01400820), `io_update` high 4 cycles, then `ready`=1.
- `load` with ftw=32'h1999_999A, pow=16'h4000, asf=14'h3FFF → writes (07, 1999999A), (08, 00004000), (09, 0000FFFC) in order, with 2-cycle gaps, then IO_UPDATE.
- `load` pulsed again during a burst, and `ftw` changed mid-burst → second load ignored, FTW word is the first latched value, exactly 3 writes occur.
- Model never returns `wr_done` on the POW write → `err`=1 after 4096 cycles in WAIT, no `io_update`, `ready`=1. A following `load` runs normally and `err` stays 1.
- `rst` asserted during IOUP and during WAIT → `io_update`/`wr_start` low on the next edge, init burst restarts at idx 0, `err` cleared.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS definitions: sequencer states, register map, word packing
package dds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_IOUP  = 3'd4
  } seq_state_e;

  localparam logic [7:0] DDS_ADDR_CFR1 = 8'h00;
  localparam logic [7:0] DDS_ADDR_CFR2 = 8'h01;
  localparam logic [7:0] DDS_ADDR_FTW  = 8'h07;
  localparam logic [7:0] DDS_ADDR_POW  = 8'h08;
  localparam logic [7:0] DDS_ADDR_ASF  = 8'h09;

  function automatic logic [31:0] pack_pow(input logic [15:0] pow);
    return {16'h0000, pow};
  endfunction

  // ASF sits in bits [15:2] of its register; the low two bits stay zero
  function automatic logic [31:0] pack_asf(input logic [13:0] asf);
    return {16'h0000, asf, 2'b00};
  endfunction

endpackage

// File: rtl/dds_cfg_seq.sv
// rtl/dds_cfg_seq.sv - DDS register-write sequencer: init burst, tone-update bursts, IO_UPDATE
module dds_cfg_seq
  import dds_pkg::*;
#(
  parameter logic [31:0] CFR1_VAL    = 32'h0000_0000,
  parameter logic [31:0] CFR2_VAL    = 32'h0140_0820,
  parameter logic [7:0]  ADDR_CFR1   = DDS_ADDR_CFR1,
  parameter logic [7:0]  ADDR_CFR2   = DDS_ADDR_CFR2,
  parameter logic [7:0]  ADDR_FTW    = DDS_ADDR_FTW,
  parameter logic [7:0]  ADDR_POW    = DDS_ADDR_POW,
  parameter logic [7:0]  ADDR_ASF    = DDS_ADDR_ASF,
  parameter int          IOUP_CYCLES = 4,
  parameter int          GAP_CYCLES  = 2,
  parameter int          TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] ftw,
  input  logic [15:0] pow,
  input  logic [13:0] asf,
  output logic        ready,
  output logic        err,
  output logic        wr_start,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic        io_update
);

  localparam int GAP_LD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int CMAX_A  = (TIMEOUT - 1 > IOUP_CYCLES - 1) ? TIMEOUT - 1 : IOUP_CYCLES - 1;
  localparam int CMAX    = (CMAX_A > GAP_LD) ? CMAX_A : GAP_LD;
  localparam int CW      = $clog2(CMAX + 2);

  seq_state_e    state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   ftw_q;
  logic [15:0]   pow_q;
  logic [13:0]   asf_q;
  logic [7:0]    list_addr;
  logic [31:0]   list_data;
  logic          last_entry;

  always_comb begin
    list_addr = ADDR_CFR1;
    list_data = CFR1_VAL;
    case (idx)
      3'd1: begin list_addr = ADDR_CFR2; list_data = CFR2_VAL;        end
      3'd2: begin list_addr = ADDR_FTW;  list_data = ftw_q;           end
      3'd3: begin list_addr = ADDR_POW;  list_data = pack_pow(pow_q); end
      3'd4: begin list_addr = ADDR_ASF;  list_data = pack_asf(asf_q); end
      default: begin list_addr = ADDR_CFR1; list_data = CFR1_VAL;     end
    endcase
  end

  assign last_entry = (idx == 3'd1) || (idx == 3'd4);

  // cnt is shared: timeout in WAIT, gap length in GAP, pulse width in IOUP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ISSUE;
      idx       <= 3'd0;
      cnt       <= '0;
      ftw_q     <= '0;
      pow_q     <= '0;
      asf_q     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      wr_start  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      io_update <= 1'b0;
    end else begin
      wr_start <= 1'b0;
      case (state)
        ST_ISSUE: begin
          wr_start <= 1'b1;
          wr_addr  <= list_addr;
          wr_data  <= list_data;
          cnt      <= CW'(TIMEOUT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wr_done) begin
            if (last_entry) begin
              state <= ST_IOUP;
            end else begin
              idx <= idx + 3'd1;
              if (GAP_CYCLES == 0) begin
                state <= ST_ISSUE;
              end else begin
                cnt   <= CW'(GAP_LD);
                state <= ST_GAP;
              end
            end
          end else if (cnt == '0) begin
            err   <= 1'b1;
            ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_ISSUE;
          else           cnt   <= cnt - CW'(1);
        end
        ST_IOUP: begin
          // io_update low here means this is the first IOUP cycle
          if (!io_update) begin
            io_update <= 1'b1;
            cnt       <= CW'(IOUP_CYCLES - 1);
          end else if (cnt == '0) begin
            io_update <= 1'b0;
            ready     <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_IDLE: begin
          if (load) begin
            ftw_q <= ftw;
            pow_q <= pow;
            asf_q <= asf;
            idx   <= 3'd2;
            ready <= 1'b0;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cfg_seq.sv
// tb/tb_dds_cfg_seq.sv - randomized bench for dds_cfg_seq against a cycle-schedule reference model
module tb_dds_cfg_seq;

  localparam int IOUP = 4;
  localparam int GAP  = 2;
  localparam int TO   = 4096;
  localparam int NLIT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] ftw = '0;
  logic [15:0] pow = '0;
  logic [13:0] asf = '0;
  logic        ready, err, wr_start, io_update;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_done = 1'b0;

  always #5 clk = ~clk;

  dds_cfg_seq dut (
    .clk(clk), .rst(rst), .load(load), .ftw(ftw), .pow(pow), .asf(asf),
    .ready(ready), .err(err), .wr_start(wr_start), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(wr_done), .io_update(io_update)
  );

  int cyc = 0;
  logic s_rst = 1'b0, s_load = 1'b0, s_done = 1'b0;
  logic [31:0] s_ftw = '0;
  logic [15:0] s_pow = '0;
  logic [13:0] s_asf = '0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_rst  <= rst;
    s_load <= load;
    s_done <= wr_done;
    s_ftw  <= ftw;
    s_pow  <= pow;
    s_asf  <= asf;
  end

  bit drop_pow = 1'b0;
  bit rand_dly = 1'b0;
  bit spurious = 1'b0;
  bit stall = 1'b0;
  bit fin = 1'b0;

  // Serial-writer stand-in: answers each wr_start after a delay, optionally never for POW
  initial begin
    int done_at;
    done_at = -1;
    forever begin
      @(posedge clk);
      #1;
      if (s_rst) done_at = -1;
      else if (wr_start && !(drop_pow && wr_addr == 8'h08))
        done_at = cyc + (rand_dly ? int'($urandom_range(1, 30)) : 20);
      if (done_at == cyc + 1) wr_done = 1'b1;
      else if (spurious && done_at <= cyc && $urandom_range(0, 63) == 0) wr_done = 1'b1;
      else wr_done = 1'b0;
    end
  end

  // Reference model state: expected outputs plus the schedule derived from the timing rules
  logic [7:0]  q_addr[$];
  logic [31:0] q_data[$];
  int  issue_at = -1, wait_from = 0, io_from = -10, io_to = -10;
  bit  waiting = 1'b0, armed = 1'b0, fin_done = 1'b0;
  logic e_ready = 1'b0, e_err = 1'b0, e_io = 1'b0, e_ws = 1'b0;
  logic [7:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  int  checks = 0, passes = 0;
  int  lit_i = 0, last_ws = 0, io_run = 0;
  logic prev_err = 1'b0, prev_io = 1'b0;
  logic [7:0]  lit_addr [NLIT] = '{8'h00, 8'h01, 8'h07, 8'h08, 8'h09,
                                   8'h07, 8'h08, 8'h07, 8'h08, 8'h09};
  logic [31:0] lit_data [NLIT] = '{32'h0000_0000, 32'h0140_0820,
                                   32'h1999_999A, 32'h0000_4000, 32'h0000_FFFC,
                                   32'h0123_4567, 32'h0000_BEEF,
                                   32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0004};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic prev_ready;
    int c;
    c = cyc;
    if (s_rst) armed = 1'b1;
    if (armed) begin
      prev_ready = e_ready;
      if (s_rst) begin
        {e_ready, e_err, e_io, e_ws} = 4'b0;
        e_addr = '0; e_data = '0;
        q_addr = '{8'h00, 8'h01};
        q_data = '{32'h0000_0000, 32'h0140_0820};
        issue_at = c + 1; waiting = 1'b0; io_from = -10; io_to = -10;
      end else begin
        e_ws = 1'b0;
        if (waiting && s_done) begin
          waiting = 1'b0;
          void'(q_addr.pop_front()); void'(q_data.pop_front());
          if (q_addr.size() == 0) begin io_from = c + 1; io_to = c + IOUP; end
          else issue_at = c + GAP + 1;
        end else if (waiting && c - wait_from == TO) begin
          e_err = 1'b1; e_ready = 1'b1; waiting = 1'b0;
          q_addr.delete(); q_data.delete();
        end
        if (c == issue_at) begin
          e_ws = 1'b1; e_addr = q_addr[0]; e_data = q_data[0];
          waiting = 1'b1; wait_from = c; issue_at = -1;
        end
        e_io = (c >= io_from && c <= io_to);
        if (c == io_to + 1) e_ready = 1'b1;
        if (prev_ready && s_load) begin
          e_ready = 1'b0;
          q_addr = '{8'h07, 8'h08, 8'h09};
          q_data = '{s_ftw, {16'h0, s_pow}, {16'h0, s_asf, 2'b00}};
          issue_at = c + 1;
        end
      end

      chk("ready", 32'(ready), 32'(e_ready));
      chk("err", 32'(err), 32'(e_err));
      chk("io_update", 32'(io_update), 32'(e_io));
      chk("wr_start", 32'(wr_start), 32'(e_ws));
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", wr_data, e_data);

      if (s_rst) begin
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wr_start", 32'(wr_start), 32'd0);
        chk("rst_io_update", 32'(io_update), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
      end
      if (wr_start) begin
        if (lit_i < NLIT) begin
          chk("lit_addr", 32'(wr_addr), 32'(lit_addr[lit_i]));
          chk("lit_data", wr_data, lit_data[lit_i]);
          lit_i++;
        end
        last_ws = c;
      end
      if (err && !prev_err) chk("timeout_cycles", 32'(c - last_ws), 32'd4096);
      if (io_update) io_run++;
      else begin
        if (prev_io && !s_rst) chk("io_width", 32'(io_run), 32'd4);
        io_run = 0;
      end
      prev_err = err;
      prev_io = io_update;
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk("literal_writes_seen", 32'(lit_i), 32'(NLIT));
      chk("no_stall", 32'(stall), 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < budget) begin tick(); k++; end
    if (ready !== 1'b1) begin
      stall = 1'b1;
      $display("FAIL wait_ready: ready still %b after %0d cycles, required 1", ready, budget);
    end
  endtask

  task automatic do_load(input logic [31:0] f, input logic [15:0] p, input logic [13:0] a);
    wait_ready(8000);
    ftw = f; pow = p; asf = a; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    wait_ready(500);

    do_load(32'h1999_999A, 16'h4000, 14'h3FFF);
    tick();
    ftw = 32'hFFFF_FFFF;
    for (int i = 0; i < 50; i++) begin
      load = (i % 7 == 3);
      pow = 16'($urandom);
      tick();
    end
    load = 1'b0;
    wait_ready(500);

    drop_pow = 1'b1;
    do_load(32'h0123_4567, 16'hBEEF, 14'h1234);
    wait_ready(6000);
    drop_pow = 1'b0;
    do_load(32'hDEAD_BEEF, 16'h0001, 14'h0001);
    wait_ready(500);

    rand_dly = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 15) == 0);
      ftw = $urandom;
      pow = 16'($urandom);
      asf = 14'($urandom);
      tick();
    end
    load = 1'b0;
    spurious = 1'b0;
    wait_ready(500);

    do_load(32'h0BAD_F00D, 16'h1357, 14'h2468);
    k = 0;
    while (io_update !== 1'b1 && k < 500) begin tick(); k++; end
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(500);

    do_load($urandom, 16'($urandom), 14'($urandom));
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(500);
    do_load($urandom, 16'($urandom), 14'($urandom));
    wait_ready(500);

    tick(3);
    fin = 1'b1;
    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
